// File: rtl/script_sequencer.sv
// Purpose : fetches 16-bit script words, decodes them, dispatches action/game words over req/ack, runs jump/wait/halt itself.
// Latency : IDLE->FETCH->DECODE, then 1 cycle for a jump, 2 for nop/illegal (DECODE->NEXT->IDLE), ack- or wait-bound for ACT/GAME/WAIT.
// Backpress: act_req/game_req stay high with stable func/arg until the matching ack is sampled; a new word is only fetched from IDLE.
//
// Ports:
//   clk, res           clock, synchronous active-low reset
//   script / pc        scriptmem read data (valid one cycle after pc changes) / scriptmem address
//   step_mode, step_btn, run   single-step (edge of step_btn) or free-run control, sampled in IDLE only
//   ms_tick            one-cycle pulse per millisecond for timed waits
//   feedback           kitchen status bits used by conditional jumps and waits
//   act_req/func/arg/ack      handshake to the action unit
//   game_req/func/ack         handshake to the game-state unit
//   busy, halted, illegal     status: not IDLE/HALT, in HALT, sticky decode error
module script_sequencer #(
    parameter int PC_WIDTH   = 8,
    parameter int PC_STEP    = 2,
    parameter int FB_WIDTH   = 8,
    parameter int WAIT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                res,
    input  logic [15:0]         script,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                step_mode,
    input  logic                step_btn,
    input  logic                run,
    input  logic                ms_tick,
    input  logic [FB_WIDTH-1:0] feedback,
    output logic                act_req,
    output logic [1:0]          act_func,
    output logic [7:0]          act_arg,
    input  logic                act_ack,
    output logic                game_req,
    output logic [1:0]          game_func,
    input  logic                game_ack,
    output logic                busy,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ACT, S_GAME, S_WAIT, S_NEXT, S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ACT  = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_WAIT = 3'b011;
    localparam logic [2:0] OP_GAME = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [PC_WIDTH-1:0] LP_STEP = PC_WIDTH'(PC_STEP);

    state_t r_state;
    state_t w_state_nxt;

    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_step_q;
    logic [WAIT_WIDTH-1:0] r_cnt;
    logic [1:0]            r_wfunc;
    logic [2:0]            r_isign;
    logic [1:0]            r_act_func;
    logic [7:0]            r_act_arg;
    logic [1:0]            r_game_func;
    logic                  r_illegal;

    // Script word fields
    logic [7:0] w_num;
    logic [2:0] w_isign;
    logic [1:0] w_func;
    logic [2:0] w_op;
    assign w_num   = script[15:8];
    assign w_isign = script[7:5];
    assign w_func  = script[4:3];
    assign w_op    = script[2:0];

    // Feedback bit lookup; indices beyond the bus read as 0.
    function automatic logic fb_bit(input logic [2:0] idx, input logic [FB_WIDTH-1:0] fb);
        logic [7:0] v;
        v = 8'(fb);
        return (int'(idx) < FB_WIDTH) ? v[idx] : 1'b0;
    endfunction

    logic w_step_rise;
    logic w_isign_ok;
    logic w_r_isign_ok;
    logic w_jump_taken;
    logic w_illegal_dec;
    logic w_wait_done;
    logic w_wbit;

    assign w_step_rise  = step_btn & ~r_step_q;
    assign w_isign_ok   = int'(w_isign) < FB_WIDTH;
    assign w_r_isign_ok = int'(r_isign) < FB_WIDTH;
    assign w_wbit       = fb_bit(r_isign, feedback);

    always_comb begin
        w_jump_taken = 1'b0;
        case (w_func)
            2'b00:   w_jump_taken = 1'b1;
            2'b01:   w_jump_taken = w_isign_ok & fb_bit(w_isign, feedback);
            2'b10:   w_jump_taken = w_isign_ok & ~fb_bit(w_isign, feedback);
            default: w_jump_taken = 1'b0;
        endcase
    end

    // Undefined opcodes, or a feedback-conditioned jump/wait pointing past the bus.
    always_comb begin
        w_illegal_dec = 1'b0;
        if (w_op == 3'b101 || w_op == 3'b110)
            w_illegal_dec = 1'b1;
        else if (w_op == OP_JUMP && (w_func == 2'b01 || w_func == 2'b10) && !w_isign_ok)
            w_illegal_dec = 1'b1;
        else if (w_op == OP_WAIT && w_func != 2'b00 && !w_isign_ok)
            w_illegal_dec = 1'b1;
    end

    // A feedback wait on a nonexistent bit would never resolve, so it exits at once.
    always_comb begin
        w_wait_done = 1'b0;
        case (r_wfunc)
            2'b00:   w_wait_done = (r_cnt == '0);
            2'b01:   w_wait_done = ~w_r_isign_ok | w_wbit;
            2'b10:   w_wait_done = ~w_r_isign_ok | ~w_wbit;
            default: w_wait_done = ~w_r_isign_ok | (r_cnt == '0) | w_wbit;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!res)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (step_mode ? w_step_rise : run) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_ACT:  w_state_nxt = S_ACT;
                    OP_GAME: w_state_nxt = S_GAME;
                    OP_WAIT: w_state_nxt = S_WAIT;
                    OP_JUMP: w_state_nxt = S_IDLE;
                    OP_HALT: w_state_nxt = S_HALT;
                    default: w_state_nxt = S_NEXT;
                endcase
            end
            S_ACT:    if (act_ack)     w_state_nxt = S_NEXT;
            S_GAME:   if (game_ack)    w_state_nxt = S_NEXT;
            S_WAIT:   if (w_wait_done) w_state_nxt = S_NEXT;
            S_NEXT:   w_state_nxt = S_IDLE;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        act_req   = (r_state == S_ACT);
        game_req  = (r_state == S_GAME);
        busy      = (r_state != S_IDLE) && (r_state != S_HALT);
        halted    = (r_state == S_HALT);
        pc        = r_pc;
        act_func  = r_act_func;
        act_arg   = r_act_arg;
        game_func = r_game_func;
        illegal   = r_illegal;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        // Tracks the button even in reset so a held button does not fire on release of reset.
        r_step_q <= step_btn;
        if (!res) begin
            r_pc        <= '0;
            r_cnt       <= '0;
            r_wfunc     <= '0;
            r_isign     <= '0;
            r_act_func  <= '0;
            r_act_arg   <= '0;
            r_game_func <= '0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    if (w_illegal_dec)
                        r_illegal <= 1'b1;
                    case (w_op)
                        OP_ACT: begin
                            r_act_func <= w_func;
                            r_act_arg  <= w_num;
                        end
                        OP_GAME: r_game_func <= w_func;
                        OP_WAIT: begin
                            // Loaded here, so a tick coinciding with entry is not counted.
                            r_cnt   <= WAIT_WIDTH'(w_num);
                            r_wfunc <= w_func;
                            r_isign <= w_isign;
                        end
                        OP_JUMP: r_pc <= w_jump_taken ? PC_WIDTH'(w_num) : r_pc + LP_STEP;
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    if (ms_tick && r_cnt != '0)
                        r_cnt <= r_cnt - WAIT_WIDTH'(1);
                end
                S_NEXT: r_pc <= r_pc + LP_STEP;
                default: ;
            endcase
        end
    end

endmodule
